// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line containers plus the L2 arbiter's FSM and source encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8words;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } l2_arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } l2_arb_src_t;

endpackage

// File: rtl/l2_arb_grant.sv
// Winner select between I and D miss requests, plus the fairness state (starvation counter or round-robin pointer).
// Latency: combinational grant; fairness state updates on the grant edge.
// Backpressure: grants only while grant_en is high; losing requester simply stays pending.
// Ports: clk, reset_n (async active-low), i_req/d_req (pending requests), grant_en (arbiter idle),
//        grant_valid (a grant happens this cycle), grant_src (winner, SRC_I/SRC_D).
// Option: L2_ARB_ROUND_ROBIN_EN selects alternating contended grants instead of D priority with starvation limit.
module l2_arb_grant
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic        d_req,
  input  logic        grant_en,
  output logic        grant_valid,
  output l2_arb_src_t grant_src
);

  assign grant_valid = grant_en & (i_req | d_req);

`ifdef L2_ARB_ROUND_ROBIN_EN

  l2_arb_src_t rr_last;

  // Contended: hand the grant to whoever did not win last time.
  always_comb begin
    grant_src = SRC_D;
    if (i_req && d_req) begin
      grant_src = (rr_last == SRC_I) ? SRC_D : SRC_I;
    end else if (i_req) begin
      grant_src = SRC_I;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last <= SRC_I;
    end else if (grant_valid) begin
      rr_last <= grant_src;
    end
  end

`else

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Contended: D wins until it has beaten a waiting I LIMIT times in a row.
  always_comb begin
    grant_src = SRC_D;
    if (i_req && d_req) begin
      grant_src = (starve_cnt == LIMIT) ? SRC_I : SRC_D;
    end else if (i_req) begin
      grant_src = SRC_I;
    end
  end

  // Only D wins over a waiting I count; uncontended D grants leave it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (grant_valid) begin
      if (grant_src == SRC_I) begin
        starve_cnt <= 4'd0;
      end else if (i_req && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

`endif

endmodule

// File: rtl/l2_arbiter.sv
// Merges L1 I-cache and D-cache line misses onto one registered L2 port and routes the response back to the owner.
// Latency: grant edge -> strobe next cycle; l2_resp at cycle N -> x_resp at N+1 (3 cycles minimum).
// Backpressure: one access in flight; new requests wait in IDLE, strobes held until l2_resp.
// Ports: clk, reset_n (async active-low); I side i_read/i_address -> i_rdata/i_resp;
//        D side d_read/d_write/d_address/d_wdata -> d_rdata/d_resp;
//        L2 side l2_read/l2_write/l2_address/l2_wdata -> l2_rdata/l2_resp.
// Option: L2_ARB_ROUND_ROBIN_EN (see l2_arb_grant); STARVE_LIMIT 1..15 applies when it is undefined.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_read,
  input  lc3b_word   i_address,
  output lc3b_8words i_rdata,
  output logic       i_resp,
  input  logic       d_read,
  input  logic       d_write,
  input  lc3b_word   d_address,
  input  lc3b_8words d_wdata,
  output lc3b_8words d_rdata,
  output logic       d_resp,
  output logic       l2_read,
  output logic       l2_write,
  output lc3b_word   l2_address,
  output lc3b_8words l2_wdata,
  input  lc3b_8words l2_rdata,
  input  logic       l2_resp
);

  l2_arb_state_t state, next_state;
  logic          op_write;
  logic          grant_valid;
  l2_arb_src_t   grant_src;

  l2_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .grant_en   (state == IDLE),
    .grant_valid(grant_valid),
    .grant_src  (grant_src)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes and responses decode straight from the state register, so reset
  // clears them immediately and they cannot glitch with the inputs.
  always_comb begin
    next_state = state;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = (grant_src == SRC_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        l2_read = 1'b1;
        if (l2_resp) next_state = RESP_I;
      end
      SERVE_D: begin
        l2_read  = ~op_write;
        l2_write = op_write;
        if (l2_resp) next_state = RESP_D;
      end
      RESP_I: begin
        i_resp     = 1'b1;
        next_state = IDLE;
      end
      RESP_D: begin
        d_resp     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured on the grant edge; d_write alone decides the op so
  // a simultaneous d_read/d_write is treated as a write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_address <= '0;
      l2_wdata   <= '0;
      op_write   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if ((state == IDLE) && grant_valid) begin
        if (grant_src == SRC_D) begin
          l2_address <= d_address;
          l2_wdata   <= d_wdata;
          op_write   <= d_write;
        end else begin
          l2_address <= i_address;
        end
      end
      if ((state == SERVE_I) && l2_resp) begin
        i_rdata <= l2_rdata;
      end
      if ((state == SERVE_D) && l2_resp && !op_write) begin
        d_rdata <= l2_rdata;
      end
    end
  end

endmodule
